// File: rtl/scale_fifo_sram_writer.sv
// Drains the scaled-pixel FIFO, packs byte pairs into 16-bit words and writes each
// frame into one of two SRAM banks over a req/ack port; publishes the last finished bank.
module scale_fifo_sram_writer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              sram_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic [11:0]       t_width,
  input  logic [11:0]       t_height,
  input  logic              fifo_scale_rdempty,
  output logic              fifo_scale_rden,
  input  logic              data_valid,
  input  logic [7:0]        sram_data_out,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              ovf
);

  // state  | meaning
  // IDLE   | no frame in progress, waiting for frame_start
  // RD     | issue one FIFO read as soon as the FIFO is not empty
  // WAIT   | wait for the read byte (data_valid) and pack it
  // WR     | hold wr_req with stable address/data until wr_ack
  // DONE   | frame complete: pulse frame_done, publish and swap banks
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       frame_bytes_q, frame_bytes_d;
  logic [23:0]       byte_cnt_q, byte_cnt_d;
  logic              byte_sel_q, byte_sel_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              ovf_q, ovf_d;
  logic              ovf_hit_q, ovf_hit_d;

  logic [23:0] frame_bytes_in;
  logic [23:0] byte_cnt_inc;
  logic        last_byte;
  logic        bank_full;

  assign frame_bytes_in = {12'd0, t_width} * {12'd0, t_height};
  assign byte_cnt_inc   = byte_cnt_q + 24'd1;
  assign last_byte      = (byte_cnt_inc == frame_bytes_q);
  // offset carries one extra bit so a full bank is visible as offset == 2^(ADDR_W-1)
  assign bank_full      = offset_q[ADDR_W-1];

  always_comb begin
    state_d         = state_q;
    frame_bytes_d   = frame_bytes_q;
    byte_cnt_d      = byte_cnt_q;
    byte_sel_d      = byte_sel_q;
    offset_d        = offset_q;
    wr_data_d       = wr_data_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    ovf_d           = ovf_q;
    ovf_hit_d       = ovf_hit_q;
    fifo_scale_rden = 1'b0;
    wr_req          = 1'b0;
    frame_done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
      end
      S_RD: begin
        if (!fifo_scale_rdempty) begin
          fifo_scale_rden = 1'b1;
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_valid) begin
          byte_cnt_d = byte_cnt_inc;
          if (!byte_sel_q) begin
            wr_data_d      = '0;
            wr_data_d[7:0] = sram_data_out;
          end else begin
            wr_data_d[15:8] = sram_data_out;
          end
          if (byte_sel_q || last_byte) begin
            byte_sel_d = 1'b0;
            if (bank_full) begin
              // bank exhausted: drop the word but keep draining the frame
              ovf_d     = 1'b1;
              ovf_hit_d = 1'b1;
              state_d   = last_byte ? S_DONE : S_RD;
            end else begin
              state_d = S_WR;
            end
          end else begin
            byte_sel_d = 1'b1;
            state_d    = S_RD;
          end
        end
      end
      S_WR: begin
        wr_req = 1'b1;
        if (wr_ack) begin
          offset_d   = offset_q + 1'b1;
          byte_sel_d = 1'b0;
          state_d    = (byte_cnt_q == frame_bytes_q) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        if (!ovf_hit_q) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new frame_start wins over everything: restart in the same bank, nothing completes.
    if (frame_start) begin
      frame_bytes_d   = frame_bytes_in;
      byte_cnt_d      = 24'd0;
      byte_sel_d      = 1'b0;
      offset_d        = '0;
      ovf_hit_d       = 1'b0;
      ovf_d           = ovf_q;
      wr_bank_d       = wr_bank_q;
      rd_bank_d       = rd_bank_q;
      wr_data_d       = wr_data_q;
      fifo_scale_rden = 1'b0;
      frame_done      = 1'b0;
      state_d         = (frame_bytes_in == 24'd0) ? S_IDLE : S_RD;
    end
  end

  always_ff @(posedge sram_clk) begin
    if (sys_rst) begin
      state_q       <= S_IDLE;
      frame_bytes_q <= '0;
      byte_cnt_q    <= '0;
      byte_sel_q    <= 1'b0;
      offset_q      <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      ovf_q         <= 1'b0;
      ovf_hit_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_bytes_q <= frame_bytes_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_sel_q    <= byte_sel_d;
      offset_q      <= offset_d;
      wr_data_q     <= wr_data_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      ovf_q         <= ovf_d;
      ovf_hit_q     <= ovf_hit_d;
    end
  end

  assign wr_addr = {wr_bank_q, offset_q[ADDR_W-2:0]};
  assign wr_data = wr_data_q;
  assign rd_bank = rd_bank_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_scale_fifo_sram_writer.sv
// Scoreboard bench: frames of random bytes are modelled as expected SRAM words;
// monitors compare every accepted write, frame_done and bank publication.
module tb_scale_fifo_sram_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // full-size instance
  logic        frame_start;
  logic [11:0] t_width, t_height;
  logic        fifo_empty, fifo_rden, data_valid;
  logic [7:0]  fifo_dout;
  logic        wr_req, wr_ack, rd_bank, frame_done, ovf;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;

  // 8-words-per-bank instance for overflow
  logic        s_frame_start;
  logic [11:0] s_w, s_h;
  logic        s_empty, s_rden, s_data_valid;
  logic [7:0]  s_dout;
  logic        s_wr_req, s_wr_ack, s_rd_bank, s_frame_done, s_ovf;
  logic [3:0]  s_wr_addr;
  logic [15:0] s_wr_data;

  scale_fifo_sram_writer #(.ADDR_W(20), .DATA_W(16)) u_dut (
    .sram_clk(clk), .sys_rst(rst), .frame_start(frame_start),
    .t_width(t_width), .t_height(t_height),
    .fifo_scale_rdempty(fifo_empty), .fifo_scale_rden(fifo_rden),
    .data_valid(data_valid), .sram_data_out(fifo_dout),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_bank(rd_bank), .frame_done(frame_done), .ovf(ovf)
  );

  scale_fifo_sram_writer #(.ADDR_W(4), .DATA_W(16)) u_dut_small (
    .sram_clk(clk), .sys_rst(rst), .frame_start(s_frame_start),
    .t_width(s_w), .t_height(s_h),
    .fifo_scale_rdempty(s_empty), .fifo_scale_rden(s_rden),
    .data_valid(s_data_valid), .sram_data_out(s_dout),
    .wr_req(s_wr_req), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_ack(s_wr_ack),
    .rd_bank(s_rd_bank), .frame_done(s_frame_done), .ovf(s_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred with no expectation", name);
  endtask

  // reference model state
  logic [7:0]  fifo_q[$];
  logic [7:0]  frame_buf[$];
  logic [35:0] exp_wr_q[$];
  logic        exp_done_q[$];
  logic        model_bank;
  int          stall_pct, ack_min, ack_max;
  bit          ack_hold;
  int          acked_cnt, done_cnt, rden_cnt;
  logic        pend;
  logic [7:0]  pend_byte;

  // frame model: byte k goes to word k/2, odd byte in the high half, missing odd byte = 00
  task automatic start_frame(input int w, input int h, input bit flush);
    int n;
    logic [7:0] b[$];
    logic [7:0] lo, hi;
    n = w * h;
    b = frame_buf;
    frame_buf.delete();
    while (b.size() < n) b.push_back(8'($urandom));
    @(posedge clk); #1;
    if (flush) begin
      exp_wr_q.delete();
      exp_done_q.delete();
      fifo_q.delete();
      model_bank = ~model_bank;
    end
    for (int i = 0; i < n; i++) fifo_q.push_back(b[i]);
    for (int i = 0; i < (n + 1) / 2; i++) begin
      lo = b[2*i];
      hi = (2*i + 1 < n) ? b[2*i+1] : 8'h00;
      exp_wr_q.push_back({model_bank, 19'(i), hi, lo});
    end
    exp_done_q.push_back(model_bank);
    model_bank  = ~model_bank;
    frame_start = 1'b1;
    t_width     = 12'(w);
    t_height    = 12'(h);
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start;
    bit got;
    start = done_cnt;
    got   = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (done_cnt > start) got = 1'b1;
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
  endtask

  task automatic wait_req(input string name, input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (wr_req) got = 1'b1;
    end
    check({name, "_req_seen"}, 64'(got), 64'd1);
  endtask

  // FIFO driver: inputs change just after the active edge
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        data_valid = 1'b0;
        fifo_empty = 1'b1;
        pend       = 1'b0;
      end else begin
        data_valid = pend;
        fifo_dout  = pend ? pend_byte : 8'($urandom);
        pend       = 1'b0;
        fifo_empty = (fifo_q.size() == 0) || (int'($urandom_range(99, 0)) < stall_pct);
      end
    end
  end

  // monitor: FIFO reads, write handshake, frame completion
  initial begin
    logic        req_seen, done_chk, exp_rb;
    logic [35:0] hold, exp;
    int          wait_cnt, ack_dly;
    req_seen = 1'b0;
    done_chk = 1'b0;
    exp_rb   = 1'b0;
    wait_cnt = 0;
    ack_dly  = 0;
    hold     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_ack   = 1'b0;
        req_seen = 1'b0;
        done_chk = 1'b0;
        continue;
      end
      if (done_chk) begin
        check("rd_bank_after_done", 64'(rd_bank), 64'(exp_rb));
        done_chk = 1'b0;
      end
      if (fifo_rden) begin
        rden_cnt++;
        check("rden_while_empty", 64'(fifo_empty), 64'd0);
        if (fifo_q.size() > 0) begin
          pend_byte = fifo_q.pop_front();
          pend      = 1'b1;
        end
      end
      if (wr_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          hold     = {wr_addr, wr_data};
          wait_cnt = 0;
          ack_dly  = int'($urandom_range(ack_max, ack_min));
        end else begin
          check("wr_hold_stable", 64'({wr_addr, wr_data}), 64'(hold));
        end
        if (!ack_hold && wait_cnt >= ack_dly) begin
          wr_ack = 1'b1;
          acked_cnt++;
          req_seen = 1'b0;
          if (exp_wr_q.size() == 0) fail_now("unexpected_write");
          else begin
            exp = exp_wr_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'(exp[35:16]));
            check("wr_data", 64'(wr_data), 64'(exp[15:0]));
          end
        end else begin
          wr_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        wr_ack   = 1'b0;
        req_seen = 1'b0;
      end
      if (frame_done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) fail_now("unexpected_frame_done");
        else begin
          exp_rb   = exp_done_q.pop_front();
          done_chk = 1'b1;
          check("writes_pending_at_done", 64'(exp_wr_q.size()), 64'd0);
        end
      end
    end
  end

  // small-instance environment: always-ready FIFO of bytes 1,2,3..., immediate ack
  int   s_left, s_rd_cnt, s_base, s_wr_idx, s_done_cnt;
  logic s_bank, s_pend;
  logic [7:0] s_byte;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        s_data_valid = 1'b0;
        s_empty      = 1'b1;
        s_pend       = 1'b0;
      end else begin
        s_data_valid = s_pend;
        s_dout       = s_pend ? s_byte : 8'h00;
        s_pend       = 1'b0;
        s_empty      = (s_left == 0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        s_wr_ack = 1'b0;
        continue;
      end
      if (s_rden) begin
        check("s_rden_while_empty", 64'(s_empty), 64'd0);
        s_rd_cnt++;
        s_byte = 8'(s_rd_cnt);
        s_pend = 1'b1;
        s_left--;
      end
      s_wr_ack = s_wr_req;
      if (s_wr_req) begin
        check("s_wr_addr", 64'(s_wr_addr), 64'({s_bank, 3'(s_wr_idx)}));
        check("s_wr_data", 64'(s_wr_data),
              64'({8'(s_base + 2*s_wr_idx + 2), 8'(s_base + 2*s_wr_idx + 1)}));
        s_wr_idx++;
      end
      if (s_frame_done) s_done_cnt++;
    end
  end

  task automatic wait_s_done(input string name, input int target, input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (s_done_cnt >= target) got = 1'b1;
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    frame_start = 1'b0; t_width = '0; t_height = '0;
    wr_ack = 1'b0; data_valid = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    s_frame_start = 1'b0; s_w = '0; s_h = '0;
    s_wr_ack = 1'b0; s_data_valid = 1'b0; s_empty = 1'b1; s_dout = '0;
    model_bank = 1'b0; stall_pct = 0; ack_min = 0; ack_max = 0; ack_hold = 1'b0;
    acked_cnt = 0; done_cnt = 0; rden_cnt = 0; pend = 1'b0; pend_byte = '0;
    s_left = 0; s_rd_cnt = 0; s_base = 0; s_wr_idx = 0; s_done_cnt = 0;
    s_bank = 1'b0; s_pend = 1'b0; s_byte = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_wr_req", 64'(wr_req), 64'd0);
    check("reset_rden", 64'(fifo_rden), 64'd0);
    check("reset_frame_done", 64'(frame_done), 64'd0);
    check("reset_rd_bank", 64'(rd_bank), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);

    // 4x2 frame, bytes 01..08, immediate ack
    for (int i = 1; i <= 8; i++) frame_buf.push_back(8'(i));
    start_frame(4, 2, 1'b0);
    wait_done("t1_4x2", 500);

    // second 4x2 frame lands in bank 1
    for (int i = 1; i <= 8; i++) frame_buf.push_back(8'(i));
    start_frame(4, 2, 1'b0);
    wait_done("t2_4x2_bank1", 500);

    // odd byte count: 3x1 frame, exactly 3 reads
    @(negedge clk);
    rden_cnt = 0;
    frame_buf.push_back(8'hAA);
    frame_buf.push_back(8'hBB);
    frame_buf.push_back(8'hCC);
    start_frame(3, 1, 1'b0);
    wait_done("t3_3x1", 500);
    @(negedge clk);
    check("t3_rden_count", 64'(rden_cnt), 64'd3);
    check("t3_fifo_drained", 64'(fifo_q.size()), 64'd0);

    // slow ack plus a randomly stalling FIFO, random frame sizes
    stall_pct = 40;
    ack_min = 5; ack_max = 5;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) begin ack_min = 0; ack_max = 3; end
      start_frame(int'($urandom_range(6, 1)), int'($urandom_range(4, 1)), 1'b0);
      wait_done("t4_random", 4000);
    end

    // abort during the fourth write of a 4x4 frame
    stall_pct = 0; ack_min = 0; ack_max = 0;
    begin
      int base;
      bit got;
      base = acked_cnt;
      start_frame(4, 4, 1'b0);
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(negedge clk);
        if (acked_cnt - base >= 3) got = 1'b1;
      end
      check("t5_three_acks", 64'(got), 64'd1);
      ack_hold = 1'b1;
      wait_req("t5_fourth", 200);
      start_frame(4, 4, 1'b1);
      @(negedge clk);
      check("t5_req_drop_on_abort", 64'(wr_req), 64'd0);
      ack_hold = 1'b0;
      wait_done("t5_restart", 1000);
    end

    // reset in the middle of a write handshake
    ack_hold = 1'b1;
    start_frame(2, 2, 1'b0);
    wait_req("t6_pre_reset", 200);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_wr_q.delete();
    exp_done_q.delete();
    fifo_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("t6_req_drop_on_reset", 64'(wr_req), 64'd0);
    check("t6_rd_bank_reset", 64'(rd_bank), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_bank = 1'b0;
    ack_hold = 1'b0;
    start_frame(2, 1, 1'b0);
    wait_done("t6_after_reset", 500);
    @(negedge clk);
    check("main_ovf_clear", 64'(ovf), 64'd0);
    check("main_exp_writes_left", 64'(exp_wr_q.size()), 64'd0);
    check("main_exp_done_left", 64'(exp_done_q.size()), 64'd0);

    // 8-word banks: 2x2 frame into bank 0, then a 4x5 frame overflows bank 1
    @(posedge clk); #1;
    s_left = 4; s_base = 0; s_bank = 1'b0; s_wr_idx = 0;
    s_frame_start = 1'b1; s_w = 12'd2; s_h = 12'd2;
    @(posedge clk); #1;
    s_frame_start = 1'b0;
    wait_s_done("t7_small_2x2", 1, 300);
    @(negedge clk);
    check("t7_small_writes", 64'(s_wr_idx), 64'd2);
    check("t7_small_ovf_clear", 64'(s_ovf), 64'd0);
    @(posedge clk); #1;
    s_left = 20; s_base = 4; s_bank = 1'b1; s_wr_idx = 0;
    s_frame_start = 1'b1; s_w = 12'd4; s_h = 12'd5;
    @(posedge clk); #1;
    s_frame_start = 1'b0;
    wait_s_done("t7_ovf_4x5", 2, 1000);
    @(negedge clk);
    @(negedge clk);
    check("t7_ovf_writes", 64'(s_wr_idx), 64'd8);
    check("t7_ovf_flag", 64'(s_ovf), 64'd1);
    check("t7_ovf_drained", 64'(s_rd_cnt), 64'd24);
    check("t7_ovf_rd_bank", 64'(s_rd_bank), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
